// File: rtl/btb_predict.sv
// ============================================================================
// Module   : btb_predict
// Purpose  : Fully associative BTB with per-entry saturating direction
//            counters and a saturating mispredict counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_predict #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 2,
  parameter int MCNT_W  = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [31:0]       pc_now,
  output logic [31:0]       pc_pre,
  output logic              hit,
  output logic [IDX_W-1:0]  hitpos,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  input  logic              upd_preright,
  output logic [MCNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_cnt_weak = CNT_W'(1) << (CNT_W - 1);
  localparam logic [MCNT_W-1:0] c_mcnt_max = {MCNT_W{1'b1}};

  logic              r_valid  [ENTRIES];
  logic [29:0]       r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [CNT_W-1:0]  r_cnt    [ENTRIES];
  logic [IDX_W-1:0]  r_rr;
  logic [MCNT_W-1:0] r_mcnt;

  logic              w_hit;
  logic [IDX_W-1:0]  w_hitpos;
  logic              w_uhit;
  logic [IDX_W-1:0]  w_upos;
  logic              w_has_free;
  logic [IDX_W-1:0]  w_free_pos;
  logic [IDX_W-1:0]  w_vpos;
  logic              w_unused_bits;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hitpos   = '0;
    w_uhit     = 1'b0;
    w_upos     = '0;
    w_has_free = 1'b0;
    w_free_pos = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == pc_now[31:2])) begin
        w_hit    = 1'b1;
        w_hitpos = IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == upd_pc[31:2])) begin
        w_uhit = 1'b1;
        w_upos = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_pos = IDX_W'(i);
      end
    end
  end

  assign w_vpos        = w_has_free ? w_free_pos : r_rr;
  assign w_unused_bits = &{1'b0, pc_now[1:0], upd_pc[1:0]};

  assign hit         = w_hit;
  assign hitpos      = w_hitpos;
  assign pred_taken  = w_hit & r_cnt[w_hitpos][CNT_W-1];
  assign pc_pre      = pred_taken ? r_target[w_hitpos] : pc_now + 32'd4;
  assign mispred_cnt = r_mcnt;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_rr   <= '0;
      r_mcnt <= '0;
    end else if (upd_valid) begin
      if (!upd_preright && (r_mcnt != c_mcnt_max))
        r_mcnt <= r_mcnt + MCNT_W'(1);
      if (w_uhit) begin
        if (upd_taken) begin
          if (r_cnt[w_upos] != c_cnt_max)
            r_cnt[w_upos] <= r_cnt[w_upos] + CNT_W'(1);
          r_target[w_upos] <= upd_target;
        end else if (r_cnt[w_upos] != '0) begin
          r_cnt[w_upos] <= r_cnt[w_upos] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Free slots are consumed first; rr only advances on eviction.
        r_valid[w_vpos]  <= 1'b1;
        r_tag[w_vpos]    <= upd_pc[31:2];
        r_target[w_vpos] <= upd_target;
        r_cnt[w_vpos]    <= c_cnt_weak;
        if (!w_has_free)
          r_rr <= r_rr + IDX_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
